// File: rtl/multiport_regfile_sb.sv
// Multi-port integer register file for the dual-issue core: N reads, M writes,
// optional write-to-read bypass, hardwired x0 and a per-register busy scoreboard.
module multiport_regfile_sb #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NRD      = 4,
  parameter int unsigned NWR      = 2,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NRD*$clog2(NREGS)-1:0] ra,
  output logic [NRD*XLEN-1:0]          rd,
  output logic [NRD-1:0]               rd_busy,
  input  logic [NWR-1:0]               we,
  input  logic [NWR*$clog2(NREGS)-1:0] wa,
  input  logic [NWR*XLEN-1:0]          wd,
  input  logic [NWR-1:0]               alloc_en,
  input  logic [NWR*$clog2(NREGS)-1:0] alloc_addr,
  output logic [NREGS-1:0]             busy_vec,
  output logic                         wr_conflict
);
  localparam int unsigned AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_nxt;
  logic [NWR-1:0]   wen_eff;
  logic [NWR-1:0]   aen_eff;
  logic             conflict_c;

  // Writes and allocations aimed at a hardwired x0 are dropped here once.
  always_comb begin
    wen_eff = '0;
    aen_eff = '0;
    for (int unsigned j = 0; j < NWR; j++) begin
      wen_eff[j] = we[j] &&
                   !((ZERO_REG != 0) && (wa[j*AW +: AW] == '0));
      aen_eff[j] = alloc_en[j] &&
                   !((ZERO_REG != 0) && (alloc_addr[j*AW +: AW] == '0));
    end
  end

  // Any two effective writes to the same register in one cycle.
  always_comb begin
    conflict_c = 1'b0;
    for (int unsigned j = 0; j < NWR; j++) begin
      for (int unsigned k = j + 1; k < NWR; k++) begin
        if (wen_eff[j] && wen_eff[k] && (wa[j*AW +: AW] == wa[k*AW +: AW]))
          conflict_c = 1'b1;
      end
    end
  end

  // Scoreboard: writeback clears, allocation sets and takes priority.
  always_comb begin
    busy_nxt = busy_q;
    for (int unsigned j = 0; j < NWR; j++) begin
      if (wen_eff[j]) busy_nxt[wa[j*AW +: AW]] = 1'b0;
    end
    for (int unsigned j = 0; j < NWR; j++) begin
      if (aen_eff[j]) busy_nxt[alloc_addr[j*AW +: AW]] = 1'b1;
    end
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  // Storage; ascending port order lets the highest-index writer win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREGS; r++) regs[r] <= '0;
      busy_q      <= '0;
      wr_conflict <= 1'b0;
    end else begin
      for (int unsigned j = 0; j < NWR; j++) begin
        if (wen_eff[j]) regs[wa[j*AW +: AW]] <= wd[j*XLEN +: XLEN];
      end
      busy_q      <= busy_nxt;
      wr_conflict <= conflict_c;
    end
  end

  assign busy_vec = busy_q;

  // Combinational read ports with optional same-cycle forwarding.
  always_comb begin
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            hit;
    logic            alloc_hit;
    logic            bsy;
    rd      = '0;
    rd_busy = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      a         = ra[i*AW +: AW];
      d         = regs[a];
      hit       = 1'b0;
      alloc_hit = 1'b0;
      if (BYPASS != 0) begin
        for (int unsigned j = 0; j < NWR; j++) begin
          if (wen_eff[j] && (wa[j*AW +: AW] == a)) begin
            hit = 1'b1;
            d   = wd[j*XLEN +: XLEN];
          end
          if (aen_eff[j] && (alloc_addr[j*AW +: AW] == a)) alloc_hit = 1'b1;
        end
      end
      bsy = hit ? alloc_hit : busy_q[a];
      if ((ZERO_REG != 0) && (a == '0)) begin
        d   = '0;
        bsy = 1'b0;
      end
      rd[i*XLEN +: XLEN] = d;
      rd_busy[i]         = bsy;
    end
  end

endmodule
